// File: rtl/id_ex_stage_if.sv
// Bundles the decode-side fields, forwarding buses and execute-side outputs of the ID/EX stage.
// The slave modport is the stage itself; the master modport is whoever drives decode and observes EX.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src_pc;
  logic        id_alu_src_imm;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;
  logic [31:0] memwb_wdata;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        load_use_stall;

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
    input  id_alu_ctrl, id_alu_src_pc, id_alu_src_imm,
    input  id_reg_write, id_mem_read, id_mem_write,
    input  stall_i, flush_i,
    input  exmem_rd, exmem_reg_write, exmem_result,
    input  memwb_rd, memwb_reg_write, memwb_wdata,
    output alu_a, alu_b, alu_ctrl, ex_store_data, ex_pc, ex_rd,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
    output load_use_stall
  );

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
    output id_alu_ctrl, id_alu_src_pc, id_alu_src_imm,
    output id_reg_write, id_mem_read, id_mem_write,
    output stall_i, flush_i,
    output exmem_rd, exmem_reg_write, exmem_result,
    output memwb_rd, memwb_reg_write, memwb_wdata,
    input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_pc, ex_rd,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
    input  load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded state, forwards EX/MEM and MEM/WB results into
// the ALU operands, and detects load-use hazards that need a one-cycle bubble.
module id_ex_stage (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);

  logic        valid;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [3:0]  ctrl;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        src_pc;
  logic        src_imm;

  logic        hazard;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // A killed instruction must never stall decode, hence the flush term.
  always_comb begin
    hazard = valid & mem_read & (rd != 5'd0) & bus.id_valid & ~bus.flush_i &
             ((bus.id_rs1_used & (bus.id_rs1 == rd)) |
              (bus.id_rs2_used & (bus.id_rs2 == rd)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rd        <= 5'd0;
      pc        <= 32'd0;
      ctrl      <= 4'd0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rs1_data  <= 32'd0;
      rs2_data  <= 32'd0;
      imm       <= 32'd0;
      src_pc    <= 1'b0;
      src_imm   <= 1'b0;
    end else if (!bus.stall_i) begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      pc       <= bus.id_pc;
      rs1      <= bus.id_rs1;
      rs2      <= bus.id_rs2;
      rs1_data <= bus.id_rs1_data;
      rs2_data <= bus.id_rs2_data;
      imm      <= bus.id_imm;
      src_pc   <= bus.id_alu_src_pc;
      src_imm  <= bus.id_alu_src_imm;
      if (bus.flush_i || hazard) begin
        valid     <= 1'b0;
        reg_write <= 1'b0;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        rd        <= 5'd0;
        ctrl      <= 4'd0;
      end else begin
        valid     <= bus.id_valid;
        reg_write <= bus.id_reg_write & bus.id_valid;
        mem_read  <= bus.id_mem_read & bus.id_valid;
        mem_write <= bus.id_mem_write & bus.id_valid;
        rd        <= bus.id_rd;
        ctrl      <= bus.id_alu_ctrl;
      end
    end
  end

  // EX/MEM is checked first so the youngest result wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs1))
      fwd_rs1 = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs1))
      fwd_rs1 = bus.memwb_wdata;
  end

  always_comb begin
    fwd_rs2 = rs2_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs2))
      fwd_rs2 = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs2))
      fwd_rs2 = bus.memwb_wdata;
  end

  assign bus.alu_a          = src_pc  ? pc  : fwd_rs1;
  assign bus.alu_b          = src_imm ? imm : fwd_rs2;
  assign bus.ex_store_data  = fwd_rs2;
  assign bus.alu_ctrl       = ctrl;
  assign bus.ex_pc          = pc;
  assign bus.ex_rd          = rd;
  assign bus.ex_valid       = valid;
  assign bus.ex_reg_write   = reg_write;
  assign bus.ex_mem_read    = mem_read;
  assign bus.ex_mem_write   = mem_write;
  assign bus.load_use_stall = hazard;

endmodule
